// File: rtl/mac_table_init_gen.sv
// MAC-table initialiser: after reset or on a start pulse, walks every host MAC in the network
// and issues one update entry per host (dest MAC, outport, local/unlocal flag) over a
// ready/valid handshake. Reports busy/done status and the count of accepted entries.
module mac_table_init_gen #(
  parameter int unsigned P_OUTPORT_WIDTH = 4,
  parameter int unsigned P_TOR_NUM       = 8,
  parameter int unsigned P_HOST_PER_TOR  = 2,
  parameter int unsigned P_MYTOR_ADDR    = 0,
  parameter logic [47:0] P_MAC_BASE      = 48'h0,
  parameter int unsigned P_GAP           = 1,
  parameter bit          P_AUTO_START    = 1'b1
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_start,
  input  logic                       i_update_ready,
  output logic [47:0]                o_update_dest_mac,
  output logic [P_OUTPORT_WIDTH-1:0] o_update_outport,
  output logic                       o_update_flag,
  output logic                       o_update_valid,
  output logic                       o_busy,
  output logic                       o_done,
  output logic [15:0]                o_entry_cnt
);

  localparam int unsigned TorW  = (P_TOR_NUM > 1) ? $clog2(P_TOR_NUM) : 1;
  localparam int unsigned HostW = (P_HOST_PER_TOR > 1) ? $clog2(P_HOST_PER_TOR) : 1;

  typedef enum logic [1:0] {StIdle, StSend, StGap, StDone} state_e;

  state_e                     state_q, state_d;
  logic [TorW-1:0]            tor_q, tor_d;
  logic [HostW-1:0]           host_q, host_d;
  logic [47:0]                mac_q, mac_d;      // MAC of the entry at (tor_q, host_q)
  logic [31:0]                gap_cnt_q, gap_cnt_d;
  logic                       auto_q, auto_d;
  logic                       valid_q, valid_d;
  logic [47:0]                dest_q, dest_d;
  logic [P_OUTPORT_WIDTH-1:0] port_q, port_d;
  logic                       flag_q, flag_d;
  logic                       busy_q, busy_d;
  logic                       done_q, done_d;
  logic [15:0]                cnt_q, cnt_d;

  logic             host_wrap;
  logic             last_entry;
  logic [TorW-1:0]  tor_nxt;
  logic [HostW-1:0] host_nxt;

  // Local hosts use their host index as outport; remote ToRs are reached via the ToR index.
  function automatic logic [P_OUTPORT_WIDTH-1:0] entry_port(input logic [TorW-1:0]  tor,
                                                            input logic [HostW-1:0] host);
    if (tor == TorW'(P_MYTOR_ADDR)) return P_OUTPORT_WIDTH'(host);
    else                            return P_OUTPORT_WIDTH'(tor);
  endfunction

  // Index walk: host index runs fastest and wraps, then the ToR index steps.
  always_comb begin
    host_wrap  = (host_q == HostW'(P_HOST_PER_TOR - 1));
    last_entry = host_wrap && (tor_q == TorW'(P_TOR_NUM - 1));
    host_nxt   = host_wrap ? '0 : host_q + HostW'(1);
    tor_nxt    = host_wrap ? tor_q + TorW'(1) : tor_q;
  end

  // Next-state logic for the sequencer and its registered outputs.
  always_comb begin
    state_d   = state_q;
    tor_d     = tor_q;
    host_d    = host_q;
    mac_d     = mac_q;
    gap_cnt_d = gap_cnt_q;
    auto_d    = auto_q;
    valid_d   = valid_q;
    dest_d    = dest_q;
    port_d    = port_q;
    flag_d    = flag_q;
    busy_d    = busy_q;
    done_d    = done_q;
    cnt_d     = cnt_q;

    unique case (state_q)
      StIdle, StDone: begin
        // Start is only honoured when not busy; auto-start fires once after reset.
        if (i_start || (state_q == StIdle && auto_q)) begin
          auto_d  = 1'b0;
          state_d = StSend;
          tor_d   = '0;
          host_d  = '0;
          mac_d   = P_MAC_BASE + 48'd1;
          cnt_d   = '0;
          done_d  = 1'b0;
          busy_d  = 1'b1;
          valid_d = 1'b1;
          dest_d  = P_MAC_BASE + 48'd1;
          port_d  = entry_port('0, '0);
          flag_d  = (TorW'(0) != TorW'(P_MYTOR_ADDR));
        end
      end

      StSend: begin
        if (i_update_ready) begin
          cnt_d = cnt_q + 16'd1;
          if (last_entry) begin
            state_d = StDone;
            valid_d = 1'b0;
            dest_d  = '0;
            port_d  = '0;
            flag_d  = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            tor_d  = tor_nxt;
            host_d = host_nxt;
            mac_d  = mac_q + 48'd1;
            if (P_GAP == 0) begin
              dest_d = mac_q + 48'd1;
              port_d = entry_port(tor_nxt, host_nxt);
              flag_d = (tor_nxt != TorW'(P_MYTOR_ADDR));
            end else begin
              state_d   = StGap;
              gap_cnt_d = '0;
              valid_d   = 1'b0;
              dest_d    = '0;
              port_d    = '0;
              flag_d    = 1'b0;
            end
          end
        end
      end

      StGap: begin
        if (gap_cnt_q == 32'(P_GAP - 1)) begin
          state_d = StSend;
          valid_d = 1'b1;
          dest_d  = mac_q;
          port_d  = entry_port(tor_q, host_q);
          flag_d  = (tor_q != TorW'(P_MYTOR_ADDR));
        end else begin
          gap_cnt_d = gap_cnt_q + 32'd1;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  // State and output registers; reset clears everything and re-arms auto-start.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= StIdle;
      tor_q     <= '0;
      host_q    <= '0;
      mac_q     <= '0;
      gap_cnt_q <= '0;
      auto_q    <= P_AUTO_START;
      valid_q   <= 1'b0;
      dest_q    <= '0;
      port_q    <= '0;
      flag_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      tor_q     <= tor_d;
      host_q    <= host_d;
      mac_q     <= mac_d;
      gap_cnt_q <= gap_cnt_d;
      auto_q    <= auto_d;
      valid_q   <= valid_d;
      dest_q    <= dest_d;
      port_q    <= port_d;
      flag_q    <= flag_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      cnt_q     <= cnt_d;
    end
  end

  assign o_update_valid    = valid_q;
  assign o_update_dest_mac = dest_q;
  assign o_update_outport  = port_q;
  assign o_update_flag     = flag_q;
  assign o_busy            = busy_q;
  assign o_done            = done_q;
  assign o_entry_cnt       = cnt_q;

endmodule
